systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder.sv | 129 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Skews vector elements onto systolic-array edge lanes (lane i delayed i+1 edges) and frames tiles.
// Optional macro SKEW_FEEDER_COUNT_EN adds a 16-bit per-tile accepted-vector counter output.

module skew_lane #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             elem_vld,
    input  logic [WIDTH-1:0] elem,
    output logic [WIDTH-1:0] lane_data,
    output logic             lane_vld
);
    logic [WIDTH-1:0] data_pipe [DEPTH];
    logic [DEPTH-1:0] vld_pipe;

    // Empty slots are zeroed at the first stage so bubbles travel as clean zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) data_pipe[k] <= '0;
            vld_pipe <= '0;
        end else begin
            data_pipe[0] <= elem_vld ? elem : '0;
            vld_pipe[0]  <= elem_vld;
            for (int k = 1; k < DEPTH; k++) begin
                data_pipe[k] <= data_pipe[k-1];
                vld_pipe[k]  <= vld_pipe[k-1];
            end
        end
    end

    assign lane_data = data_pipe[DEPTH-1];
    assign lane_vld  = vld_pipe[DEPTH-1];
endmodule

module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic [LANES*WIDTH-1:0] feed_data,
    output logic [LANES-1:0]       feed_valid,
    output logic                   busy,
    output logic                   done
`ifdef SKEW_FEEDER_COUNT_EN
    ,
    output logic [15:0]            vec_count
`endif
);
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam int CW = (LANES > 2) ? $clog2(LANES - 1) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_q;
    logic          accept;

    assign in_ready = (state != FLUSH);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            // Last FLUSH cycle ends exactly as the final lane shows the tile's last element.
            done_q <= (state == FLUSH) && (cnt == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = CW'(LANES - 2);
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            FLUSH: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        skew_lane #(
            .WIDTH(WIDTH),
            .DEPTH(g + 1)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .elem_vld (accept),
            .elem     (in_data[g*WIDTH +: WIDTH]),
            .lane_data(feed_data[g*WIDTH +: WIDTH]),
            .lane_vld (feed_valid[g])
        );
    end

`ifdef SKEW_FEEDER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count <= '0;
        end else if (accept) begin
            if (state == IDLE)              vec_count <= 16'd1;
            else if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (LANES=4, WIDTH=16) with immediate-assertion checks.

module tb_systolic_skew_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [63:0] feed_data;
    logic [3:0]  feed_valid;
    logic        busy;
    logic        done;
`ifdef SKEW_FEEDER_COUNT_EN
    logic [15:0] vec_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.WIDTH(16), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .feed_data (feed_data),
        .feed_valid(feed_valid),
        .busy      (busy),
        .done      (done)
`ifdef SKEW_FEEDER_COUNT_EN
        ,
        .vec_count (vec_count)
`endif
    );

    function automatic logic [63:0] vec(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input string tag, input logic [63:0] d, input logic [3:0] v,
                        input logic exp_done);
        chk({tag, ".data"}, feed_data, d);
        chk({tag, ".valid"}, {60'd0, feed_valid}, {60'd0, v});
        chk({tag, ".done"}, {63'd0, done}, {63'd0, exp_done});
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'd0, 1'b0);
        #2;
        snap("reset", 64'd0, 4'b0000, 1'b0);
        chk("reset.busy", {63'd0, busy}, 64'd0);
        #10 rst = 1'b0;
        chk("post_reset.ready", {63'd0, in_ready}, 64'd1);

        // single tile
        drive(1'b1, vec(1, 2, 3, 4), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t1.c0", vec(1, 0, 0, 0), 4'b0001, 1'b0);
        chk("t1.c0.busy", {63'd0, busy}, 64'd1);
        chk("t1.c0.ready", {63'd0, in_ready}, 64'd0);
        tick();
        snap("t1.c1", vec(0, 2, 0, 0), 4'b0010, 1'b0);
        chk("t1.c1.ready", {63'd0, in_ready}, 64'd0);
        tick();
        snap("t1.c2", vec(0, 0, 3, 0), 4'b0100, 1'b0);
        chk("t1.c2.busy", {63'd0, busy}, 64'd1);
        tick();
        snap("t1.c3", vec(0, 0, 0, 4), 4'b1000, 1'b1);
        chk("t1.c3.busy", {63'd0, busy}, 64'd0);
        chk("t1.c3.ready", {63'd0, in_ready}, 64'd1);
        tick();
        snap("t1.c4", 64'd0, 4'b0000, 1'b0);

        // back-to-back
        drive(1'b1, vec(1, 2, 3, 4), 1'b0);
        tick();
        chk("t2.ready1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, vec(5, 6, 7, 8), 1'b0);
        tick();
        chk("t2.ready2", {63'd0, in_ready}, 64'd1);
        drive(1'b1, vec(9, 10, 11, 12), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t2.c2", vec(9, 6, 3, 0), 4'b0111, 1'b0);
        chk("t2.c2.ready", {63'd0, in_ready}, 64'd0);
        tick();
        snap("t2.c3", vec(0, 10, 7, 4), 4'b1110, 1'b0);
        tick();
        snap("t2.c4", vec(0, 0, 11, 8), 4'b1100, 1'b0);
        tick();
        snap("t2.c5", vec(0, 0, 0, 12), 4'b1000, 1'b1);
`ifdef SKEW_FEEDER_COUNT_EN
        chk("t2.count", {48'd0, vec_count}, 64'd3);
`endif
        tick();
        snap("t2.c6", 64'd0, 4'b0000, 1'b0);

        // bubble
        drive(1'b1, vec(1, 2, 3, 4), 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t3.c0", vec(1, 0, 0, 0), 4'b0001, 1'b0);
        tick();
        snap("t3.c1", vec(0, 2, 0, 0), 4'b0010, 1'b0);
        chk("t3.c1.ready", {63'd0, in_ready}, 64'd1);
        chk("t3.c1.busy", {63'd0, busy}, 64'd1);
        drive(1'b1, vec(5, 6, 7, 8), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t3.c2", vec(5, 0, 3, 0), 4'b0101, 1'b0);
        tick();
        snap("t3.c3", vec(0, 6, 0, 4), 4'b1010, 1'b0);
        tick();
        snap("t3.c4", vec(0, 0, 7, 0), 4'b0100, 1'b0);
        tick();
        snap("t3.c5", vec(0, 0, 0, 8), 4'b1000, 1'b1);
        tick();

        // overlap: next tile accepted in the done cycle
        drive(1'b1, vec(1, 2, 3, 4), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        tick();
        tick();
        tick();
        snap("t4.done1", vec(0, 0, 0, 4), 4'b1000, 1'b1);
        chk("t4.done1.ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, vec(21, 22, 23, 24), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t4.c0", vec(21, 0, 0, 0), 4'b0001, 1'b0);
        tick();
        snap("t4.c1", vec(0, 22, 0, 0), 4'b0010, 1'b0);
        tick();
        snap("t4.c2", vec(0, 0, 23, 0), 4'b0100, 1'b0);
        tick();
        snap("t4.done2", vec(0, 0, 0, 24), 4'b1000, 1'b1);
        tick();

        // reset mid-tile
        drive(1'b1, vec(1, 2, 3, 4), 1'b0);
        tick();
        drive(1'b1, vec(5, 6, 7, 8), 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        snap("t5.async", 64'd0, 4'b0000, 1'b0);
        chk("t5.async.busy", {63'd0, busy}, 64'd0);
        #2 rst = 1'b0;
        chk("t5.ready", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            snap("t5.quiet", 64'd0, 4'b0000, 1'b0);
        end

        // signed bit-exact pass-through
        drive(1'b1, vec(16'hFFFB, 16'hFFFD, 16'h7FFF, 16'h8000), 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        snap("t6.c0", vec(16'hFFFB, 0, 0, 0), 4'b0001, 1'b0);
`ifdef SKEW_FEEDER_COUNT_EN
        chk("t6.count", {48'd0, vec_count}, 64'd1);
`endif
        tick();
        snap("t6.c1", vec(0, 16'hFFFD, 0, 0), 4'b0010, 1'b0);
        tick();
        snap("t6.c2", vec(0, 0, 16'h7FFF, 0), 4'b0100, 1'b0);
        tick();
        snap("t6.c3", vec(0, 0, 0, 16'h8000), 4'b1000, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
